fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage. It drives the PC register's load and increment controls, runs the req/ack handshake to instruction memory, and holds one fetched instruction until decode accepts it. It also applies branch/jump redirects, discarding any fetch already in flight. It sits between the PC register and decode. The PC register increments only when `pc_inc` is high; there is no free-running increment.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_buf.sv | 39 +++
 rtl/fetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and FSM state encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [2:0] {
        StBoot,
        StFetch,
        StValid,
        StDrain,
        StHalted
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a fetched instruction and its address.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_consume,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_consume || i_flush) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC load/increment, the imem req/ack handshake,
// and redirect handling in front of a one-entry instruction buffer.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_load_pc,
    output logic [ADDR_W-1:0]  o_pc_in,
    output logic               o_pc_inc,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    input  logic               i_halt
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_d;
    logic              r_in_reset;
    logic [ADDR_W-1:0] r_req_addr;
    logic              w_redirect;
    logic              w_buf_load;
    logic              w_buf_consume;
    logic              w_buf_flush;

    // r_in_reset keeps BOOT quiet while rst is held, so the boot pulse lands
    // in the first cycle after reset is released.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StBoot;
            r_in_reset <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_in_reset <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_addr <= '0;
        end else if (r_state == StFetch) begin
            r_req_addr <= i_pc;
        end
    end

    assign w_redirect = i_redirect_valid && (r_state != StBoot);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StBoot:   w_state_d = r_in_reset ? StBoot : StFetch;
            StFetch: begin
                if (w_redirect) begin
                    w_state_d = i_imem_ack ? StFetch : StDrain;
                end else if (i_imem_ack) begin
                    w_state_d = StValid;
                end
            end
            StValid: begin
                if (w_redirect) begin
                    w_state_d = StFetch;
                end else if (i_instr_ready) begin
                    w_state_d = i_halt ? StHalted : StFetch;
                end
            end
            StDrain: begin
                if (i_imem_ack) begin
                    w_state_d = i_halt ? StHalted : StFetch;
                end
            end
            StHalted: begin
                if (!i_halt) begin
                    w_state_d = StFetch;
                end
            end
            default:  w_state_d = StBoot;
        endcase
    end

    always_comb begin
        o_load_pc     = 1'b0;
        o_pc_in       = '0;
        o_pc_inc      = 1'b0;
        o_imem_req    = 1'b0;
        o_imem_addr   = '0;
        w_buf_load    = 1'b0;
        w_buf_consume = 1'b0;
        w_buf_flush   = 1'b0;
        if (w_redirect) begin
            o_load_pc = 1'b1;
            o_pc_in   = i_redirect_pc;
        end
        unique case (r_state)
            StBoot: begin
                o_load_pc = !r_in_reset;
                o_pc_in   = r_in_reset ? '0 : RESET_VECTOR;
            end
            StFetch: begin
                o_imem_req  = 1'b1;
                o_imem_addr = i_pc;
                if (i_imem_ack && !w_redirect) begin
                    w_buf_load = 1'b1;
                    o_pc_inc   = 1'b1;
                end
            end
            StValid: begin
                w_buf_flush   = w_redirect;
                w_buf_consume = i_instr_ready && !w_redirect;
            end
            StDrain: begin
                o_imem_req  = 1'b1;
                o_imem_addr = r_req_addr;
            end
            StHalted: begin
            end
            default: begin
            end
        endcase
    end

    fetch_buf u_fetch_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_buf_load),
        .i_consume (w_buf_consume),
        .i_flush   (w_buf_flush),
        .i_instr   (i_imem_rdata),
        .i_pc      (i_pc),
        .o_valid   (o_instr_valid),
        .o_instr   (o_instr),
        .o_pc      (o_instr_pc)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a behavioural PC register.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        load_pc;
    logic [15:0] pc_in;
    logic        pc_inc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // PC register living next to the fetch stage.
    initial pc = 16'h1234;
    always @(posedge clk) begin
        if (load_pc) pc <= pc_in;
        else if (pc_inc) pc <= pc + 16'h0001;
    end

    fetch_ctrl #(
        .RESET_VECTOR (16'h0000)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc             (pc),
        .o_load_pc        (load_pc),
        .o_pc_in          (pc_in),
        .o_pc_inc         (pc_inc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata),
        .o_instr_valid    (instr_valid),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc),
        .i_instr_ready    (instr_ready),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt           (halt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " load_pc"}, {15'd0, load_pc}, 16'h0000);
        check({tag, " pc_inc"}, {15'd0, pc_inc}, 16'h0000);
        check({tag, " imem_req"}, {15'd0, imem_req}, 16'h0000);
        check({tag, " instr_valid"}, {15'd0, instr_valid}, 16'h0000);
        check({tag, " pc_in"}, pc_in, 16'h0000);
        check({tag, " imem_addr"}, imem_addr, 16'h0000);
        check({tag, " instr"}, instr, 16'h0000);
        check({tag, " instr_pc"}, instr_pc, 16'h0000);
    endtask

    initial begin
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 16'h0000;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt           = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        check_reset_outputs("reset");

        // Release reset: BOOT pulse one cycle later, first request the cycle after
        rst = 1'b0;
        #1;
        check("rel load_pc", {15'd0, load_pc}, 16'h0000);
        tick();
        #1;
        check("boot load_pc", {15'd0, load_pc}, 16'h0001);
        check("boot pc_in", pc_in, 16'h0000);
        check("boot imem_req", {15'd0, imem_req}, 16'h0000);
        tick();
        #1;
        check("first req", {15'd0, imem_req}, 16'h0001);
        check("first addr", imem_addr, 16'h0000);

        // Zero-wait sequential fetch, decode always ready
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'hA000 + 16'(i);
            #1;
            check("seq addr", imem_addr, 16'(i));
            check("seq pc_inc", {15'd0, pc_inc}, 16'h0001);
            check("seq load_pc", {15'd0, load_pc}, 16'h0000);
            tick();
            imem_ack = 1'b0;
            if (i == 2) instr_ready = 1'b0;
            #1;
            check("seq valid", {15'd0, instr_valid}, 16'h0001);
            check("seq instr", instr, 16'hA000 + 16'(i));
            check("seq instr_pc", instr_pc, 16'(i));
            check("seq no req", {15'd0, imem_req}, 16'h0000);
            check("seq no inc", {15'd0, pc_inc}, 16'h0000);
            tick();
        end

        // Decode stall for 4 cycles on the entry at pc 2
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall valid", {15'd0, instr_valid}, 16'h0001);
            check("stall instr", instr, 16'hA002);
            check("stall req", {15'd0, imem_req}, 16'h0000);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        check("stall instr_pc", instr_pc, 16'h0002);
        tick();
        instr_ready = 1'b0;
        #1;
        check("post stall req", {15'd0, imem_req}, 16'h0001);
        check("post stall addr", imem_addr, 16'h0003);

        // 3-cycle ack delay
        for (int i = 0; i < 2; i++) begin
            #1;
            check("slow req", {15'd0, imem_req}, 16'h0001);
            check("slow addr", imem_addr, 16'h0003);
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 16'hB003;
        #1;
        check("slow ack addr", imem_addr, 16'h0003);
        check("slow ack valid", {15'd0, instr_valid}, 16'h0000);
        tick();
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("slow valid", {15'd0, instr_valid}, 16'h0001);
        check("slow instr", instr, 16'hB003);
        check("slow instr_pc", instr_pc, 16'h0003);
        tick();
        instr_ready = 1'b0;

        // Redirect to 0x0040 during a 2-cycle-delayed fetch
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        check("rd addr", imem_addr, 16'h0004);
        check("rd load_pc", {15'd0, load_pc}, 16'h0001);
        check("rd pc_in", pc_in, 16'h0040);
        check("rd pc_inc", {15'd0, pc_inc}, 16'h0000);
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        imem_rdata     = 16'hDEAD;
        #1;
        check("drain req", {15'd0, imem_req}, 16'h0001);
        check("drain addr", imem_addr, 16'h0004);
        check("drain pc_inc", {15'd0, pc_inc}, 16'h0000);
        tick();
        imem_ack = 1'b0;
        #1;
        check("drain discard", {15'd0, instr_valid}, 16'h0000);
        check("drain next req", {15'd0, imem_req}, 16'h0001);
        check("drain next addr", imem_addr, 16'h0040);

        // Redirect in VALID with instr_ready simultaneously
        imem_ack   = 1'b1;
        imem_rdata = 16'hC040;
        tick();
        imem_ack       = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        #1;
        check("rv instr_pc", instr_pc, 16'h0040);
        check("rv load_pc", {15'd0, load_pc}, 16'h0001);
        check("rv pc_in", pc_in, 16'hFFFF);
        check("rv pc_inc", {15'd0, pc_inc}, 16'h0000);
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        check("rv dropped", {15'd0, instr_valid}, 16'h0000);
        check("rv req", {15'd0, imem_req}, 16'h0001);
        check("rv addr", imem_addr, 16'hFFFF);

        // Fetch at 0xFFFF, then halt in VALID
        imem_ack   = 1'b1;
        imem_rdata = 16'hE0FF;
        tick();
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        halt        = 1'b1;
        #1;
        check("wrap instr_pc", instr_pc, 16'hFFFF);
        check("wrap pc", pc, 16'h0000);
        tick();
        instr_ready = 1'b0;
        #1;
        check("halted req", {15'd0, imem_req}, 16'h0000);
        check("halted valid", {15'd0, instr_valid}, 16'h0000);
        tick();
        #1;
        check("halted hold req", {15'd0, imem_req}, 16'h0000);
        halt = 1'b0;
        #1;
        check("halt drop req", {15'd0, imem_req}, 16'h0000);
        tick();
        #1;
        check("resume req", {15'd0, imem_req}, 16'h0001);
        check("resume addr", imem_addr, 16'h0000);

        // Reset mid-FETCH
        rst = 1'b1;
        tick();
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick();
        #1;
        check("reboot load_pc", {15'd0, load_pc}, 16'h0001);
        tick();
        #1;
        check("reboot req", {15'd0, imem_req}, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
